conv_row_requant: RTL

CONV_ROW_REQUANT -- requirements
Module: conv_row_requant

---
 rtl/conv_row_requant_pkg.sv | 23 ++
 rtl/conv_row_fifo.sv | 51 +++++
 rtl/conv_row_requant.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/conv_row_requant_pkg.sv
// Shared types and arithmetic helpers for the row requantiser.
// Frame FSM state and saturation/rounding constants.
package conv_row_requant_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    function automatic longint sat_hi(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // half an LSB of the shifted result, zero when no shift
    function automatic longint round_add(input int sh);
        return (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/conv_row_fifo.sv
// Row FIFO: power-of-two depth, full/empty flags.
// Push while full succeeds only when a pop happens the same cycle.
module conv_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;
    assign dout  = mem[rp];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            if (wr_ok && !rd_ok) cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end

endmodule

// File: rtl/conv_row_requant.sv
// Row requantiser: bias add, round/shift/saturate, row FIFO, frame tracking.
// Optional CONV_ROW_REQUANT_RELU_EN clamps negative results to zero.
module conv_row_requant #(
    parameter int DATA_WIDTH  = 8,
    parameter int RESULT_W    = 6,
    parameter int RESULT_D    = 4,
    parameter int RESULT_H    = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic [RESULT_D*RESULT_W*4*DATA_WIDTH-1:0] in_data,
    input  logic [RESULT_D*RESULT_W*$clog2(RESULT_H)-1:0] in_addr,
    input  logic [RESULT_D*RESULT_W-1:0] in_wren,
    input  logic [RESULT_D*4*DATA_WIDTH-1:0] bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [RESULT_D*RESULT_W*DATA_WIDTH-1:0] out_data,
    output logic [$clog2(RESULT_H)-1:0] out_row,
    output logic out_last,
    output logic out_val,
    input  logic out_rdy,
    output logic overflow,
    output logic seq_err,
    output logic frame_done
);

    import conv_row_requant_pkg::*;

    localparam int ACC_W = 4 * DATA_WIDTH;
    localparam int LANES = RESULT_D * RESULT_W;
    localparam int RH_AW = $clog2(RESULT_H);
    localparam int OUT_W = LANES * DATA_WIDTH;
    localparam int FW    = OUT_W + RH_AW;
    localparam int W2    = ACC_W + 2;

    localparam logic signed [W2-1:0] SAT_HI = W2'(sat_hi(DATA_WIDTH));
    localparam logic signed [W2-1:0] SAT_LO = W2'(sat_lo(DATA_WIDTH));
    localparam logic [RH_AW-1:0] LAST_ROW = RH_AW'(RESULT_H - 1);

    logic                    cap;
    logic [RH_AW-1:0]        cap_row;
    logic                    unused_lanes;

    logic                    s1_val;
    logic [SHIFT_WIDTH-1:0]  s1_shift;
    logic [RH_AW-1:0]        s1_row;
    logic signed [ACC_W:0]   s1_sum [LANES];
    logic [OUT_W-1:0]        s2_data;

    logic [FW-1:0]           head;
    logic                    full;
    logic                    empty;
    logic                    pop;

    frame_state_t            state;
    frame_state_t            state_n;
    logic [RH_AW-1:0]        exp_row;
    logic [RH_AW-1:0]        exp_n;

    assign cap     = in_wren[0];
    assign cap_row = in_addr[RH_AW-1:0];
    assign unused_lanes = ^{in_addr[LANES*RH_AW-1:RH_AW],
                            in_wren[LANES-1:1]};

    // S1: per-lane bias add at ACC_W+1 bits, sample shift and row
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_val <= 1'b0;
        end else begin
            s1_val <= cap;
        end
        s1_shift <= shift;
        s1_row   <= cap_row;
        for (int i = 0; i < LANES; i++) begin
            s1_sum[i] <=
                $signed({in_data[i*ACC_W+ACC_W-1],
                         in_data[i*ACC_W +: ACC_W]})
              + $signed({bias[(i/RESULT_W)*ACC_W+ACC_W-1],
                         bias[(i/RESULT_W)*ACC_W +: ACC_W]});
        end
    end

    // S2: per-lane round, shift, optional clamp, saturate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [W2-1:0]  rnd;
        logic signed [W2-1:0]  shf;
        logic signed [W2-1:0]  clp;
        logic [DATA_WIDTH-1:0] sat;

        // one lane of requantisation
        always_comb begin
            rnd = {s1_sum[g][ACC_W], s1_sum[g]}
                + W2'(round_add(int'(s1_shift)));
            shf = rnd >>> s1_shift;
`ifdef CONV_ROW_REQUANT_RELU_EN
            clp = shf[W2-1] ? '0 : shf;
`else
            clp = shf;
`endif
            if (clp > SAT_HI)      sat = SAT_HI[DATA_WIDTH-1:0];
            else if (clp < SAT_LO) sat = SAT_LO[DATA_WIDTH-1:0];
            else                   sat = clp[DATA_WIDTH-1:0];
        end

        assign s2_data[g*DATA_WIDTH +: DATA_WIDTH] = sat;
    end

    conv_row_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_val),
        .din   ({s1_row, s2_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign out_val    = !empty;
    assign pop        = out_val && out_rdy;
    assign out_data   = out_val ? head[OUT_W-1:0] : '0;
    assign out_row    = out_val ? head[FW-1 -: RH_AW] : '0;
    assign out_last   = out_val && (out_row == LAST_ROW);
    assign frame_done = out_last && out_rdy;

    // sticky overflow when a row is dropped on a full FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (s1_val && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // frame FSM state, expected row and sticky sequence error
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            exp_row <= '0;
            seq_err <= 1'b0;
        end else begin
            state   <= state_n;
            exp_row <= exp_n;
            if (cap && (cap_row != exp_row)) seq_err <= 1'b1;
        end
    end

    // next frame state; expected row follows the captured row
    always_comb begin
        state_n = state;
        exp_n   = exp_row;
        if (cap) begin
            if (cap_row == LAST_ROW) begin
                state_n = IDLE;
                exp_n   = '0;
            end else begin
                state_n = ACTIVE;
                exp_n   = cap_row + 1'b1;
            end
        end
    end

endmodule
